// File: rtl/seq_multiplier.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier, one add-and-shift per clock.
// Start/busy/done handshake; product register holds the result after done.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     sum_s;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    // Carry-out of the partial add lands in the top bit after the shift
    if (product_q[0]) begin
      sum_s = {1'b0, product_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end else begin
      sum_s = {1'b0, product_q[2*WIDTH-1:WIDTH]};
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_CALC;
          mcand_d   = multiplicand;
          product_d = {{WIDTH{1'b0}}, multiplier};
          cnt_d     = {CNT_W{1'b0}};
          busy_d    = 1'b1;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_CALC: begin
        product_d = {sum_s, product_q[WIDTH-1:1]};
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        product_d = {(2*WIDTH){1'b0}};
        cnt_d     = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset wins over start and aborts any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      product_q <= {(2*WIDTH){1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
